muldiv_sequencer: RTL and testbench

- Multi-cycle HI/LO unit for the EX stage. Executes MIPS MULT/MULTU/DIV/DIVU by iterating a 33-bit add/subtract step 32 times.
- Owns the HI and LO architectural registers.
- Asserts stall to the pipeline while busy. Also serves MTHI/MTLO writes.

---
 rtl/muldiv_sequencer_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes, FSM states
// and the default datapath width.
package muldiv_sequencer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_DEF  = 32;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic funct_valid(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared 33-bit add/subtract datapath: a shift-add
// multiply step or a restoring divide step, selected by mode.
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             mode,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             shift_bit,
    output logic [WIDTH:0]   acc_next,
    output logic             q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = acc + (shift_bit ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_sh = {acc[WIDTH-1:0], shift_bit};
        diff   = rem_sh - {1'b0, operand};
        acc_next = '0;
        q_bit    = 1'b0;
        if (mode == MODE_DIV) begin
            // Partial remainder stays below the divisor, so bit WIDTH of diff is the borrow.
            acc_next = diff[WIDTH] ? rem_sh : diff;
            q_bit    = ~diff[WIDTH];
        end else begin
            // The sum's low bit shifts into the top of P_lo; the carry drops into P_hi.
            acc_next = {1'b0, sum[WIDTH:1]};
            q_bit    = sum[0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency iterative MULT/MULTU/DIV/DIVU
// with pipeline stall, flush and MTHI/MTLO writes.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t            state;
    logic [1:0]        op_sel;
    logic [WIDTH-1:0]  a_raw;
    logic [WIDTH-1:0]  b_raw;
    logic              sign_a;
    logic              sign_b;
    logic [WIDTH-1:0]  opnd;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH:0]    acc;
    logic [CNT_W-1:0]  cnt;

    logic              is_div;
    logic              is_signed;
    logic [WIDTH:0]    acc_next;
    logic              q_bit;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_dw(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic is_negative(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        return sgn && (sv < 0);
    endfunction

    assign is_div    = op_sel[1];
    assign is_signed = ~op_sel[0];

    assign mag_a = cond_neg(a_raw, is_negative(a_raw, is_signed));
    assign mag_b = cond_neg(b_raw, is_negative(b_raw, is_signed));

    // Multiply: acc = {carry, P_hi}, shreg = P_lo. Divide: acc = R, shreg = Q.
    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode     (is_div ? MODE_DIV : MODE_MUL),
        .acc      (acc),
        .operand  (opnd),
        .shift_bit(is_div ? shreg[WIDTH-1] : shreg[0]),
        .acc_next (acc_next),
        .q_bit    (q_bit)
    );

    assign prod_fix = cond_neg_dw({acc[WIDTH-1:0], shreg}, sign_a ^ sign_b);
    assign quo_fix  = cond_neg(shreg, sign_a ^ sign_b);
    assign rem_fix  = cond_neg(acc[WIDTH-1:0], sign_a);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            op_sel <= '0;
            a_raw  <= '0;
            b_raw  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            shreg  <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            if (!busy && hi_we) hi <= wdata;
            if (!busy && lo_we) lo <= wdata;

            unique case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start && funct_valid(Signal)) begin
                        state  <= ST_PREP;
                        busy   <= 1'b1;
                        op_sel <= Signal[1:0];
                        a_raw  <= dataA;
                        b_raw  <= dataB;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sign_a <= is_negative(a_raw, is_signed);
                        sign_b <= is_negative(b_raw, is_signed);
                        if (is_div) begin
                            opnd  <= mag_b;
                            shreg <= mag_a;
                        end else begin
                            opnd  <= mag_a;
                            shreg <= mag_b;
                        end
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= acc_next;
                        shreg <= is_div ? {shreg[WIDTH-2:0], q_bit} : {q_bit, shreg[WIDTH-1:1]};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            // Divide by zero returns all-ones quotient and the raw dividend.
                            if (b_raw == '0) begin
                                lo <= '1;
                                hi <= a_raw;
                            end else begin
                                lo <= quo_fix;
                                hi <= rem_fix;
                            end
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a result scoreboard.
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [5:0]  Signal = '0;
    logic [31:0] dataA  = '0;
    logic [31:0] dataB  = '0;
    logic        flush  = 1'b0;
    logic        hi_we  = 1'b0;
    logic        lo_we  = 1'b0;
    logic [31:0] wdata  = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .WIDTH(32),
        .ITER (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .Signal(Signal),
        .dataA (dataA),
        .dataB (dataB),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el);
        start  = 1'b1;
        Signal = f;
        dataA  = a;
        dataB  = b;
        sb_q.push_back({eh, el});
    endtask

    // Called at the negedge where start was driven; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int inj);
        int   bad;
        res_t exp;
        bad = 0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i == 1 || i == inj + 1) start = 1'b0;
            if ({busy, done} !== 2'b10) bad++;
            if (i == inj) begin
                start  = 1'b1;
                Signal = F_MULTU;
                dataA  = 32'd9;
                dataB  = 32'd9;
            end
        end
        check({tag, " busy1..34"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({tag, " done@35"}, {62'd0, busy, done}, 64'd1);
        n_tests++;
        assert (sb_q.size() > 0)
        else begin
            n_fail++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({tag, " hi_lo"}, {hi, lo}, exp);
        end
    endtask

    initial begin
        int dones;
        #1;
        check("reset hi_lo", {hi, lo}, 64'd0);
        check("reset busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        start_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_done("multu_max", 0);
        @(negedge clk);
        start_op(F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        wait_done("mult_neg", 0);
        @(negedge clk);
        start_op(F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_done("div_neg", 0);
        @(negedge clk);
        start_op(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("divu", 0);
        @(negedge clk);
        start_op(F_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        wait_done("div_zero", 0);
        @(negedge clk);
        start_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        wait_done("div_ovf", 0);
        @(negedge clk);

        // MTHI preload, then flush an op mid-RUN
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {32'd0, hi}, {32'd0, 32'h1234});
        start  = 1'b1;
        Signal = F_MULTU;
        dataA  = 32'd3;
        dataB  = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy_done", {62'd0, busy, done}, 64'd0);
        check("flush hi_lo", {hi, lo}, {32'h1234, 32'h80000000});
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("flush no_done", 64'(dones), 64'd0);

        // start while busy is ignored, then back-to-back start from DONE
        start_op(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("ignore_busy", 5);
        start_op(F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0);
        wait_done("b2b", 0);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000ABCD;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_in_done", {hi, lo}, {32'h0000ABCD, 32'h0000ABCD});
        check("after_done idle", {62'd0, busy, done}, 64'd0);

        // asynchronous reset in the middle of RUN
        start  = 1'b1;
        Signal = F_DIVU;
        dataA  = 32'd100;
        dataB  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset hi_lo", {hi, lo}, 64'd0);
        check("async_reset busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset idle", {62'd0, busy, done}, 64'd0);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
